// File: rtl/cnn_seq_pkg.sv
// Shared types for the CNN frame sequencer: FSM state encoding and sticky error codes.
package cnn_seq_pkg;
  typedef enum logic [2:0] {IDLE, RST, SOF, STREAM, EOF, WAIT, DONE} seq_state_t;

  localparam logic [31:0] ERR_NONE          = 32'd0;
  localparam logic [31:0] ERR_TIMEOUT       = 32'd1;
  localparam logic [31:0] ERR_INVALID_START = 32'd2;
  localparam logic [31:0] ERR_ABORT         = 32'd3;
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with registered read data and a single-cycle flush.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;

  // Pointers are power-of-2 wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        pop_data <= mem[rd_ptr];
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/cnn_frame_sequencer.sv
// Streams one buffered frame into the CNN core: reset, SOF, pixel beats, EOF, then waits for the result.
module cnn_frame_sequencer #(
  parameter int IMG_W          = 32,
  parameter int IMG_H          = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_start,
  input  logic                               cmd_abort,
  input  logic                               wr_valid,
  input  logic [7:0]                         wr_data,
  output logic                               wr_ready,
  output logic                               cnn_reset,
  output logic                               frame_start,
  output logic                               pixel_valid,
  output logic [7:0]                         pixel_data,
  output logic                               frame_complete,
  input  logic                               cnn_busy,
  input  logic                               cnn_result_valid,
  output logic                               seq_busy,
  output logic                               seq_done,
  output logic [31:0]                        frame_count,
  output logic [31:0]                        error_code,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]   pix_sent
);
  import cnn_seq_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  seq_state_t    state;
  logic [TW-1:0] tmo_cnt;
  logic          res_q, fifo_full, fifo_empty, pop;
  logic [CW-1:0] fifo_count;
  logic          unused_count;

  assign wr_ready     = !fifo_full;
  assign seq_busy     = (state != IDLE);
  assign unused_count = ^fifo_count;
  // pix_sent counts pops, so it lines up with the beat that a pop produces next cycle.
  assign pop = (state == STREAM) && !fifo_empty && !cnn_busy && !cmd_abort &&
               (pix_sent != PW'(NPIX));

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wr_valid),
    .push_data(wr_data),
    .pop      (pop),
    .pop_data (pixel_data),
    .flush    (cmd_abort),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      cnn_reset      <= 1'b0;
      frame_start    <= 1'b0;
      pixel_valid    <= 1'b0;
      frame_complete <= 1'b0;
      seq_done       <= 1'b0;
      frame_count    <= '0;
      error_code     <= ERR_NONE;
      pix_sent       <= '0;
      tmo_cnt        <= '0;
      res_q          <= 1'b0;
    end else begin
      res_q          <= cnn_result_valid;
      cnn_reset      <= 1'b0;
      frame_start    <= 1'b0;
      frame_complete <= 1'b0;
      seq_done       <= 1'b0;
      pixel_valid    <= pop;
      if (pop) pix_sent <= pix_sent + PW'(1);
      if (cmd_start && state != IDLE) error_code <= ERR_INVALID_START;
      case (state)
        IDLE: if (cmd_start && !cmd_abort) begin
          state      <= RST;
          cnn_reset  <= 1'b1;
          error_code <= ERR_NONE;
          pix_sent   <= '0;
        end
        RST: begin
          state       <= SOF;
          frame_start <= 1'b1;
        end
        SOF: state <= STREAM;
        STREAM: if (pix_sent == PW'(NPIX)) begin
          state          <= EOF;
          frame_complete <= 1'b1;
        end
        EOF: begin
          state   <= WAIT;
          tmo_cnt <= '0;
        end
        WAIT: if (cnn_result_valid && !res_q) begin
          state       <= DONE;
          seq_done    <= 1'b1;
          frame_count <= frame_count + 32'd1;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state      <= IDLE;
          error_code <= ERR_TIMEOUT;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Abort overrides whatever the state machine decided this cycle.
      if (cmd_abort && state != IDLE) begin
        state          <= IDLE;
        error_code     <= ERR_ABORT;
        cnn_reset      <= 1'b1;
        frame_start    <= 1'b0;
        frame_complete <= 1'b0;
        seq_done       <= 1'b0;
        pixel_valid    <= 1'b0;
        frame_count    <= frame_count;
      end
    end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Randomized bench for cnn_frame_sequencer against a queue-based model of the pixel stream.
`timescale 1ns/1ps
module tb_cnn_frame_sequencer;
  localparam int IMG_W = 4, IMG_H = 2, NPIX = IMG_W * IMG_H;
  localparam int DEPTH = 16, TMO = 20;
  localparam int PW = $clog2(NPIX + 1);

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_start = 1'b0, cmd_abort = 1'b0, wr_valid = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          cnn_busy = 1'b0, cnn_result_valid = 1'b0;
  logic          wr_ready, cnn_reset, frame_start, pixel_valid, frame_complete, seq_busy, seq_done;
  logic [7:0]    pixel_data;
  logic [31:0]   frame_count, error_code;
  logic [PW-1:0] pix_sent;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int beats = 0, n_rst = 0, n_sof = 0, n_eof = 0, n_done = 0;
  int c_rst = 0, c_sof = 0, c_eof = 0, c_done = 0, c_first = 0, c_last = 0;
  int exp_fc = 0;
  logic busy_prev = 1'b0;
  byte unsigned mq[$];

  cnn_frame_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .cnn_reset(cnn_reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .frame_complete(frame_complete), .cnn_busy(cnn_busy),
    .cnn_result_valid(cnn_result_valid), .seq_busy(seq_busy), .seq_done(seq_done),
    .frame_count(frame_count), .error_code(error_code), .pix_sent(pix_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every beat must carry the oldest byte software wrote and not yet consumed.
  always @(negedge clk) if (rst_n) begin
    if (cnn_reset) begin n_rst++; c_rst = cyc; end
    if (frame_start) begin n_sof++; c_sof = cyc; beats = 0; end
    if (pixel_valid) begin
      beats++;
      if (beats == 1) c_first = cyc;
      c_last = cyc;
      chk("beat_q_nonempty", 32'(mq.size() != 0), 32'd1);
      if (mq.size() != 0) chk("beat_data", 32'(pixel_data), 32'(mq.pop_front()));
      chk("beat_pix_sent", 32'(pix_sent), 32'(beats));
      chk("beat_after_busy", 32'(busy_prev), 32'd0);
    end
    if (frame_complete) begin n_eof++; c_eof = cyc; chk("eof_beats", 32'(beats), NPIX); end
    if (seq_done) begin n_done++; c_done = cyc; end
    busy_prev = cnn_busy;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input byte unsigned d);
    wr_valid = 1'b1; wr_data = d;
    if (mq.size() < DEPTH) mq.push_back(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic start(output int s);
    beats = 0; cmd_start = 1'b1; s = cyc; tick(); cmd_start = 1'b0;
  endtask

  task automatic abort();
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0; mq.delete();
  endtask

  task automatic pulse_result(output int r);
    cnn_result_valid = 1'b1; r = cyc; tick(); cnn_result_valid = 1'b0;
  endtask

  task automatic wait_eof(input int e0);
    for (int i = 0; i < 400 && n_eof == e0; i++) tick();
    chk("eof_seen", 32'(n_eof), 32'(e0 + 1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && seq_busy; i++) tick();
    chk("back_to_idle", 32'(seq_busy), 32'd0);
  endtask

  task automatic wait_beats(input int b);
    for (int i = 0; i < 400 && beats < b; i++) tick();
    chk("beats_reached", 32'(beats >= b), 32'd1);
  endtask

  initial begin
    int s, r, e0, d0, r0, b0, wl, idle_c, npre, nwr;
    tick(3);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_cnn_reset", 32'(cnn_reset), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_pixel_valid", 32'(pixel_valid), 0);
    chk("rst_pixel_data", 32'(pixel_data), 0);
    chk("rst_frame_complete", 32'(frame_complete), 0);
    chk("rst_seq_busy", 32'(seq_busy), 0);
    chk("rst_seq_done", 32'(seq_done), 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_error_code", error_code, 0);
    chk("rst_pix_sent", 32'(pix_sent), 0);
    rst_n = 1'b1; tick(2);

    // Prefilled frame, back-to-back beats, result 5 cycles after EOF.
    e0 = n_eof; d0 = n_done; r0 = n_rst;
    for (int i = 0; i < 8; i++) wr(8'(16 + i));
    start(s); wait_eof(e0);
    tick(4); pulse_result(r); wait_idle(); exp_fc++;
    chk("t1_rst_lat", c_rst, s + 1);
    chk("t1_sof_lat", c_sof, c_rst + 1);
    chk("t1_first_beat", c_first, c_sof + 2);
    chk("t1_last_beat", c_last, c_first + 7);
    chk("t1_eof_lat", c_eof, c_last + 1);
    chk("t1_done_lat", c_done, r + 1);
    chk("t1_frame_count", frame_count, exp_fc);
    chk("t1_error", error_code, 0);
    chk("t1_n_done", n_done, d0 + 1);
    chk("t1_n_rst", n_rst, r0 + 1);

    // Empty FIFO, trickle writes every 3 cycles.
    e0 = n_eof; wl = 0; start(s);
    fork
      begin for (int i = 0; i < 8; i++) begin wl = cyc; wr(8'(64 + i)); tick(2); end end
      begin wait_eof(e0); tick(2); pulse_result(r); end
    join
    wait_idle(); exp_fc++;
    chk("t2_last_beat_lat", c_last, wl + 2);
    chk("t2_frame_count", frame_count, exp_fc);

    // Backpressure from the CNN mid-stream.
    for (int i = 0; i < 8; i++) wr(8'(128 + i));
    e0 = n_eof; start(s); wait_beats(3);
    b0 = beats; cnn_busy = 1'b1; tick(10);
    chk("t3_busy_hold", beats, b0 + 1);
    cnn_busy = 1'b0; wait_eof(e0); tick(); pulse_result(r); wait_idle(); exp_fc++;
    chk("t3_frame_count", frame_count, exp_fc);

    // Result never arrives.
    for (int i = 0; i < 8; i++) wr(8'($urandom));
    e0 = n_eof; d0 = n_done; start(s); wait_eof(e0);
    for (int i = 0; i < 100 && seq_busy; i++) tick();
    idle_c = cyc;
    chk("t4_idle_cycle", idle_c, c_eof + 1 + TMO);
    chk("t4_error", error_code, 1);
    chk("t4_no_done", n_done, d0);
    chk("t4_frame_count", frame_count, exp_fc);

    // Abort in IDLE flushes only; abort beats a simultaneous start.
    for (int i = 0; i < 3; i++) wr(8'($urandom));
    abort(); tick();
    chk("idle_abort_error", error_code, 1);
    r0 = n_rst; cmd_start = 1'b1; cmd_abort = 1'b1; tick(); cmd_start = 1'b0; cmd_abort = 1'b0; tick(2);
    chk("abort_wins_busy", 32'(seq_busy), 0);
    chk("abort_wins_no_rst", n_rst, r0);

    // Stray start mid-stream, then an abort mid-frame.
    for (int i = 0; i < 8; i++) wr(8'($urandom));
    e0 = n_eof; start(s); wait_beats(2);
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("t5_invalid_start", error_code, 2);
    wait_eof(e0); tick(); pulse_result(r); wait_idle(); exp_fc++;
    chk("t5_frame_count", frame_count, exp_fc);
    chk("t5_error_sticky", error_code, 2);
    for (int i = 0; i < 8; i++) wr(8'($urandom));
    start(s);
    chk("t5_error_cleared", error_code, 0);
    for (int i = 0; i < 100 && pix_sent < 3; i++) tick();
    r0 = n_rst; e0 = n_eof; d0 = n_done;
    abort(); tick(3);
    chk("t5_abort_rst_pulse", n_rst, r0 + 1);
    chk("t5_abort_error", error_code, 3);
    chk("t5_abort_idle", 32'(seq_busy), 0);
    chk("t5_abort_no_eof", n_eof, e0);
    chk("t5_abort_no_done", n_done, d0);
    chk("t5_abort_beats", beats, 3);

    // Overfill: 17 writes into 16 entries.
    for (int i = 1; i <= 17; i++) begin
      wr(8'(i));
      if (i >= 15) chk("t6_wr_ready", 32'(wr_ready), 32'(i < DEPTH));
    end
    e0 = n_eof; start(s); wait_eof(e0); tick(); pulse_result(r); wait_idle(); exp_fc++;
    chk("t6_frame_count", frame_count, exp_fc);

    // Random frames; leftover bytes 9..16 feed the first one.
    for (int f = 0; f < 6; f++) begin
      npre = (mq.size() < NPIX) ? $urandom_range(0, NPIX - mq.size()) : 0;
      for (int i = 0; i < npre; i++) wr(8'($urandom));
      nwr = ((mq.size() < NPIX) ? NPIX - mq.size() : 0) + $urandom_range(0, 2);
      e0 = n_eof; d0 = n_done; start(s);
      fork
        begin
          for (int i = 0; i < nwr; i++) begin
            int gap;
            wr(8'($urandom));
            gap = $urandom_range(0, 2);
            if (gap > 0) tick(gap);
          end
        end
        begin
          for (int g = 0; g < 400 && n_eof == e0; g++) begin cnn_busy = ($urandom_range(0, 2) == 0); tick(); end
          cnn_busy = 1'b0;
        end
        begin wait_eof(e0); tick($urandom_range(1, 10)); pulse_result(r); end
      join
      wait_idle(); exp_fc++;
      chk("rnd_done_lat", c_done, r + 1);
      chk("rnd_n_done", n_done, d0 + 1);
      chk("rnd_frame_count", frame_count, exp_fc);
      chk("rnd_error", error_code, 0);
    end

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 4; i++) wr(8'($urandom));
    start(s); wait_beats(2);
    rst_n = 1'b0; #1;
    chk("arst_busy", 32'(seq_busy), 0);
    chk("arst_pixel_valid", 32'(pixel_valid), 0);
    chk("arst_cnn_reset", 32'(cnn_reset), 0);
    chk("arst_frame_count", frame_count, 0);
    chk("arst_pix_sent", 32'(pix_sent), 0);
    chk("arst_wr_ready", 32'(wr_ready), 1);
    mq.delete(); exp_fc = 0;
    tick(); rst_n = 1'b1; tick(2);
    for (int i = 0; i < 8; i++) wr(8'($urandom));
    e0 = n_eof; start(s); wait_eof(e0); tick(); pulse_result(r); wait_idle(); exp_fc++;
    chk("post_arst_frame_count", frame_count, exp_fc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
Sequences one CNN frame end to end.
- Buffers pixels written by MicroBlaze through a small FIFO.
- Issues cnn_reset, frame_start, IMG_W*IMG_H pixel beats and frame_complete, in that order.
- Waits for cnn_result_valid, with a timeout.
- Sits between the AXI register block and the CNN core, and replaces per-pixel software pulsing with hardware streaming.

Parameters:
IMG_W, 32, image width in pixels
IMG_H, 32, image height in pixels
FIFO_DEPTH, 16, pixel FIFO entries, power of 2, >=2
TIMEOUT_CYCLES, 100000, maximum cycles in WAIT_RESULT before error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_start  in  1  one-cycle pulse: begin a frame
cmd_abort  in  1  one-cycle pulse: abort the frame and flush the FIFO
wr_valid  in  1  pixel write strobe from the AXI side
wr_data  in  8  pixel byte
wr_ready  out  1  FIFO not full
cnn_reset  out  1  one-cycle reset pulse to the CNN
frame_start  out  1  one-cycle start-of-frame pulse
pixel_valid  out  1  pixel beat valid
pixel_data  out  8  pixel byte, valid when pixel_valid=1
frame_complete  out  1  one-cycle end-of-frame pulse
cnn_busy  in  1  CNN busy; pixel beats stall while it is high
cnn_result_valid  in  1  CNN result ready (level or pulse)
seq_busy  out  1  state != IDLE
seq_done  out  1  one-cycle pulse when a frame completes successfully
frame_count  out  32  successful frames, wraps at 2^32
error_code  out  32  sticky last error: 0 none, 1 timeout, 2 invalid start, 3 abort
pix_sent  out  clog2(IMG_W*IMG_H+1)  pixels sent in the current frame

Behaviour:
- Reset: every output is 0 except wr_ready=1. State IDLE, FIFO empty, counters 0.
- All CNN-side outputs are registered.
- FSM states: IDLE -> RST -> SOF -> STREAM -> EOF -> WAIT -> DONE -> IDLE.
- IDLE:
  - cmd_start moves to RST.
  - error_code is cleared to 0 on that transition.
- RST: cnn_reset=1 for exactly 1 cycle, then SOF.
- SOF: frame_start=1 for exactly 1 cycle, then STREAM.
- STREAM:
  - Each cycle, if FIFO not empty and cnn_busy=0, pop one entry.
  - The popped entry drives pixel_valid=1 and pixel_data on the next cycle (1-cycle pop-to-beat latency).
  - Back-to-back beats are allowed.
  - pix_sent increments per beat.
  - When the beat with pix_sent reaching IMG_W*IMG_H is issued, go to EOF. No further pops occur in that frame.
- EOF: frame_complete=1 for 1 cycle, then WAIT. The timeout counter is cleared on entry.
- WAIT:
  - The rising edge of cnn_result_valid goes to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no edge: error_code=1, then IDLE without a seq_done.
- DONE:
  - seq_done=1 for 1 cycle.
  - frame_count increments.
  - Then IDLE; pix_sent holds its final value until the next cmd_start.
- cmd_start outside IDLE: ignored for sequencing; error_code=2; the frame continues.
- cmd_abort in any non-IDLE state:
  - Next state IDLE, FIFO flushed, error_code=3.
  - cnn_reset pulses 1 cycle.
  - No frame_complete and no seq_done.
- cmd_abort in IDLE: flushes the FIFO only; error_code is unchanged.
- cmd_abort and cmd_start in the same cycle: abort wins.
- FIFO writes:
  - Accepted in every state when wr_ready=1, so software may prefill in IDLE.
  - A write while full is dropped and the FIFO is not modified.
  - Simultaneous push and pop on a full or empty FIFO is legal; count is unchanged when both occur on a non-empty, non-full FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
- Leftover FIFO data after DONE stays for the next frame.
- Asynchronous reset mid-frame: everything returns to its reset values immediately, with no pulses.

Decomposition:
- Package cnn_seq_pkg holds:
  - state enum seq_state_t {IDLE, RST, SOF, STREAM, EOF, WAIT, DONE};
  - error constants ERR_NONE, ERR_TIMEOUT, ERR_INVALID_START, ERR_ABORT.
- Sub-module pixel_fifo:
  - Synchronous FIFO with parameter DEPTH.
  - Ports: push, push_data, pop, pop_data, flush, full, empty, count.
  - pop_data is registered.
  - Instantiated once.

Test Plan:
1. IMG_W=4, IMG_H=2: prefill 8 bytes 0x10..0x17 in IDLE, pulse cmd_start, pulse cnn_result_valid 5 cycles after frame_complete -> cnn_reset, frame_start, 8 beats 0x10..0x17 in order, frame_complete, seq_done; frame_count=1; error_code=0.
2. Start with an empty FIFO, then write 1 byte every 3 cycles -> pixel_valid is gapped and each beat appears 1 cycle after its pop; total 8 beats; frame completes.
3. Hold cnn_busy=1 for 10 cycles mid-STREAM -> no beats while busy; streaming resumes with no lost or duplicated data.
4. TIMEOUT_CYCLES=20 with no cnn_result_valid -> error_code=1 at cycle 20 of WAIT; seq_busy=0; no seq_done; frame_count unchanged.
5. Pulse cmd_start during STREAM -> error_code=2 and the frame still completes. Then cmd_abort at pix_sent=3 -> cnn_reset pulse, FIFO empty, error_code=3, no frame_complete.
6. Write 17 bytes into the 16-deep FIFO in IDLE -> wr_ready=0 after the 16th write, the 17th is dropped, and the frame streams bytes 1..8.
